// File: rtl/uart_rx_pkg.sv
// Shared UART frame definitions: FSM state encodings, frame constants and
// baud-timing helper used by the receive path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

  // Clocks per serial bit, truncated like the transmitter does.
  function automatic int unsigned clks_per_bit(input int unsigned freq_hz,
                                               input int unsigned baud);
    return freq_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// Generic two-flop synchronizer for a single asynchronous input.
// Both flops come out of reset at RST_VAL so an idle line reads idle at once.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= RST_VAL;
      q_r    <= RST_VAL;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling timed directly on clk, one-cycle done
// strobe with the received byte and a framing-error flag.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned clk_freq  = 1000000,
  parameter int unsigned baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       doneRx,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(clk_freq, baud_rate);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned TMR_W        = $clog2(CLKS_PER_BIT);

  localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(HALF_BIT - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic             rx_s;
  rx_state_e        state_r,  state_nxt_s;
  logic [TMR_W-1:0] timer_r,  timer_nxt_s;
  logic [2:0]       idx_r,    idx_nxt_s;
  logic [7:0]       shreg_r,  shreg_nxt_s;
  logic [7:0]       data_r,   data_nxt_s;
  logic             ferr_r,   ferr_nxt_s;
  logic             done_r,   done_nxt_s;
  logic             busy_r,   busy_nxt_s;
  logic             tick_s;

  sync2 #(
    .RST_VAL (IDLE_LEVEL)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      timer_r <= TMR_ZERO;
      idx_r   <= 3'd0;
      shreg_r <= 8'h00;
      data_r  <= 8'h00;
      ferr_r  <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      timer_r <= timer_nxt_s;
      idx_r   <= idx_nxt_s;
      shreg_r <= shreg_nxt_s;
      data_r  <= data_nxt_s;
      ferr_r  <= ferr_nxt_s;
      done_r  <= done_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  assign tick_s = (timer_r == TMR_LAST);

  // Next-state, bit timing and frame assembly
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = tick_s ? TMR_ZERO : (timer_r + TMR_ONE);
    idx_nxt_s   = idx_r;
    shreg_nxt_s = shreg_r;
    data_nxt_s  = data_r;
    ferr_nxt_s  = ferr_r;
    done_nxt_s  = 1'b0;
    busy_nxt_s  = busy_r;

    case (state_r)
      ST_IDLE: begin
        timer_nxt_s = TMR_ZERO;
        if (rx_s != IDLE_LEVEL) begin
          state_nxt_s = ST_START;
          busy_nxt_s  = 1'b1;
        end else begin
          busy_nxt_s  = 1'b0;
        end
      end

      ST_START: begin
        if (timer_r == TMR_HALF) begin
          if (rx_s == IDLE_LEVEL) begin
            // Start bit did not survive to mid-bit: treat as a glitch.
            state_nxt_s = ST_IDLE;
            busy_nxt_s  = 1'b0;
          end else begin
            state_nxt_s = ST_DATA;
            timer_nxt_s = TMR_ZERO;
            idx_nxt_s   = 3'd0;
          end
        end else begin
          state_nxt_s = ST_START;
        end
      end

      ST_DATA: begin
        if (tick_s) begin
          shreg_nxt_s[idx_r] = rx_s;
          if (idx_r == IDX_LAST) begin
            state_nxt_s = ST_STOP;
          end else begin
            idx_nxt_s = idx_r + 3'd1;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end

      ST_STOP: begin
        if (tick_s) begin
          data_nxt_s = shreg_r;
          ferr_nxt_s = ~rx_s;
          done_nxt_s = 1'b1;
          // Leaving at mid-stop lets a back-to-back start edge be caught.
          state_nxt_s = (rx_s == IDLE_LEVEL) ? ST_IDLE : ST_BREAK;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end

      ST_BREAK: begin
        if (rx_s == IDLE_LEVEL) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BREAK;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
        timer_nxt_s = TMR_ZERO;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  assign rx_data   = data_r;
  assign doneRx    = done_r;
  assign frame_err = ferr_r;
  assign busy      = busy_r;

endmodule
